// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and instruction-memory write bundle for imm_encoder.
// master = loader/sequencer side, slave = imm_encoder.
interface imm_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 2,
  parameter int ADDR_WIDTH = 8
);
  logic                  valid_i;
  logic                  ready_o;
  logic [IMM_WIDTH-1:0]  ImmSrc_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] base_i;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  full_o;
  logic                  err_o;

  modport master (
    output valid_i, ImmSrc_i, imm_i, base_i,
    input  ready_o, we_o, waddr_o, wdata_o, count_o, full_o, err_o
  );

  modport slave (
    input  valid_i, ImmSrc_i, imm_i, base_i,
    output ready_o, we_o, waddr_o, wdata_o, count_o, full_o, err_o
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a signed immediate into the RISC-V I/B/J field
// positions of a base instruction and writes the result to instruction
// memory at an auto-incrementing word address.
// Optional build macro IMM_RANGE_CHECK_EN: reject immediates that do not fit
// the selected format (sticky err_o, no write). Without it, excess bits are
// dropped and err_o is tied low.
//
// state | meaning
// IDLE  | ready for a request; capture fields on valid_i
// ENC   | build the word, range check, pick write or reject
// WR    | we_o high for this one cycle, count advances at its end
// FULL  | every word address used; only rst_i leaves
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 2,
  parameter int ADDR_WIDTH = 8
) (
  input logic         clk_i,
  input logic         rst_i,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

  localparam logic [IMM_WIDTH-1:0] FMT_I = 'b01;
  localparam logic [IMM_WIDTH-1:0] FMT_B = 'b11;
  localparam logic [IMM_WIDTH-1:0] FMT_J = 'b10;
  localparam logic [ADDR_WIDTH:0]  FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  logic [IMM_WIDTH-1:0]  fmt_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic                  ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  full_q;
  logic                  range_ok;

  function automatic logic [DATA_WIDTH-1:0] encode(
    input logic [IMM_WIDTH-1:0]  fmt,
    input logic [DATA_WIDTH-1:0] imm,
    input logic [DATA_WIDTH-1:0] base
  );
    logic [DATA_WIDTH-1:0] w;
    w = base;
    case (fmt)
      FMT_I: w[31:20] = imm[11:0];
      FMT_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      FMT_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: ;
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  logic err_q;

  // B and J offsets are byte offsets to halfword-aligned targets, so bit 0
  // must be clear as well as the value fitting the signed field.
  function automatic logic in_range(
    input logic [IMM_WIDTH-1:0]  fmt,
    input logic [DATA_WIDTH-1:0] imm
  );
    case (fmt)
      FMT_I:   return imm == {{20{imm[11]}}, imm[11:0]};
      FMT_B:   return !imm[0] && (imm == {{19{imm[12]}}, imm[12:0]});
      FMT_J:   return !imm[0] && (imm == {{11{imm[20]}}, imm[20:0]});
      default: return 1'b1;
    endcase
  endfunction

  assign range_ok   = in_range(fmt_q, imm_q);
  assign bus.err_o  = err_q;
`else
  logic unused_imm_bits;

  assign range_ok        = 1'b1;
  assign bus.err_o       = 1'b0;
  assign unused_imm_bits = ^{imm_q[DATA_WIDTH-1:21], imm_q[0]};
`endif

  assign count_next = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Sequencer: capture, encode/check, single-cycle write, count and fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      fmt_q   <= '0;
      imm_q   <= '0;
      base_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            fmt_q   <= bus.ImmSrc_i;
            imm_q   <= bus.imm_i;
            base_q  <= bus.base_i;
            ready_q <= 1'b0;
            state   <= ENC;
          end
        end
        ENC: begin
          if (!range_ok) begin
`ifdef IMM_RANGE_CHECK_EN
            err_q   <= 1'b1;
`endif
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            wdata_q <= encode(fmt_q, imm_q, base_q);
            waddr_q <= count_q[ADDR_WIDTH-1:0];
            we_q    <= 1'b1;
            state   <= WR;
          end
        end
        WR: begin
          count_q <= count_next;
          if (count_next == FULL_COUNT) begin
            full_q <= 1'b1;
            state  <= FULL;
          end else begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        FULL: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.we_o    = we_q;
  assign bus.waddr_o = waddr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.count_o = count_q;
  assign bus.full_o  = full_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against an
// arithmetic reference model of the field packing and range rules.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [8:0] exp_count = '0;
  bit         exp_err   = 1'b0;

  always #5 clk = ~clk;

  imm_encoder_if #(.DATA_WIDTH(32), .IMM_WIDTH(2), .ADDR_WIDTH(8)) bus ();
  imm_encoder_if #(.DATA_WIDTH(32), .IMM_WIDTH(2), .ADDR_WIDTH(2)) sb ();

  imm_encoder #(.DATA_WIDTH(32), .IMM_WIDTH(2), .ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  imm_encoder #(.DATA_WIDTH(32), .IMM_WIDTH(2), .ADDR_WIDTH(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .bus(sb)
  );

  // Reference packing: clear the format's immediate fields, then OR in the
  // shifted immediate slices.
  function automatic logic [31:0] model_word(input logic [1:0] fmt, input logic [31:0] imm,
                                             input logic [31:0] base);
    case (fmt)
      2'd1: return (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
      2'd3: return (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                 | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                 | (((imm >> 11) & 32'h1) << 7);
      2'd2: return (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                 | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                 | (((imm >> 12) & 32'hFF) << 12);
      default: return base;
    endcase
  endfunction

  function automatic bit model_ok(input logic [1:0] fmt, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = $signed(imm);
    case (fmt)
      2'd1: return (s >= -2048) && (s <= 2047);
      2'd3: return (imm[0] == 1'b0) && (s >= -4096) && (s <= 4095);
      2'd2: return (imm[0] == 1'b0) && (s >= -1048576) && (s <= 1048575);
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] legal_imm(input logic [1:0] fmt);
    int r;
    case (fmt)
      2'd1: begin r = int'($urandom_range(0, 4095));    if (r >= 2048)   r -= 4096;    end
      2'd3: begin r = int'($urandom_range(0, 8191));    if (r >= 4096)   r -= 8192;    r &= ~1; end
      2'd2: begin r = int'($urandom_range(0, 2097151)); if (r >= 1048576) r -= 2097152; r &= ~1; end
      default: r = int'($urandom);
    endcase
    return 32'(r);
  endfunction

  // Drives one request on the 8-bit-address instance and samples the cycles
  // after the accept edge (N+1 .. N+3).
  task automatic run_req(input logic [1:0] fmt, input logic [31:0] imm, input logic [31:0] base,
                         output logic we1, output logic we2, output logic we3,
                         output logic err2, output logic rdy2, output logic rdy3,
                         output logic [7:0] waddr2, output logic [31:0] wdata2,
                         output logic [8:0] count3);
    int waited = 0;
    while (bus.ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (bus.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: ready_o=%b required 1", bus.ready_o);
    end
    bus.valid_i  = 1'b1;
    bus.ImmSrc_i = fmt;
    bus.imm_i    = imm;
    bus.base_i   = base;
    @(negedge clk);
    we1 = bus.we_o;
    bus.valid_i = 1'b0;
    @(negedge clk);
    we2 = bus.we_o; err2 = bus.err_o; rdy2 = bus.ready_o;
    waddr2 = bus.waddr_o; wdata2 = bus.wdata_o;
    @(negedge clk);
    we3 = bus.we_o; rdy3 = bus.ready_o; count3 = bus.count_o;
  endtask

  task automatic test_reset();
    n_tests++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    n_tests++; if (bus.we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.we_o); end
    n_tests++; if (bus.waddr_o !== 8'h0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", bus.waddr_o); end
    n_tests++; if (bus.wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.wdata_o); end
    n_tests++; if (bus.count_o !== 9'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", bus.count_o); end
    n_tests++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full_o); end
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_tests++; if (sb.ready_o !== 1'b1 || sb.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_small: ready=%b full=%b want 1 0", sb.ready_o, sb.full_o); end
  endtask

  task automatic test_directed();
    logic we1, we2, we3, err2, rdy2, rdy3;
    logic [7:0] wa; logic [31:0] wd; logic [8:0] c3;
    run_req(2'b01, 32'hFFFF_FFFF, 32'h0000_0013, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (we1 !== 1'b0 || we2 !== 1'b1 || we3 !== 1'b0) begin n_fail++; $display("FAIL i_we_timing: got %b%b%b want 010", we1, we2, we3); end
    n_tests++; if (wa !== 8'd0) begin n_fail++; $display("FAIL i_waddr: got %h want 0", wa); end
    n_tests++; if (wd !== 32'hFFF0_0013) begin n_fail++; $display("FAIL i_wdata: got %h want fff00013", wd); end
    n_tests++; if (c3 !== 9'd1 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL i_count_ready: got %0d %b want 1 1", c3, rdy3); end
    exp_count = 9'd1;
    run_req(2'b10, 32'h0000_0800, 32'h0000_006F, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (we2 !== 1'b1 || wd !== 32'h0010_006F) begin n_fail++; $display("FAIL j_wdata: got we=%b %h want 1 0010006f", we2, wd); end
    n_tests++; if (wa !== 8'd1) begin n_fail++; $display("FAIL j_waddr: got %h want 1", wa); end
    exp_count = 9'd2;
    run_req(2'b11, 32'h0000_0008, 32'h0000_0063, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (we2 !== 1'b1 || wd !== 32'h0000_0463) begin n_fail++; $display("FAIL b_wdata: got we=%b %h want 1 00000463", we2, wd); end
    n_tests++; if (c3 !== 9'd3) begin n_fail++; $display("FAIL b_count: got %0d want 3", c3); end
    exp_count = 9'd3;
  endtask

  task automatic test_range();
    logic we1, we2, we3, err2, rdy2, rdy3;
    logic [7:0] wa; logic [31:0] wd; logic [8:0] c3;
`ifdef IMM_RANGE_CHECK_EN
    run_req(2'b01, 32'h0000_0800, 32'h0000_0013, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (err2 !== 1'b1 || rdy2 !== 1'b1) begin n_fail++; $display("FAIL range_i_err: got err=%b ready=%b want 1 1", err2, rdy2); end
    n_tests++; if (we2 !== 1'b0 || we3 !== 1'b0 || c3 !== exp_count) begin n_fail++; $display("FAIL range_i_nowrite: got we=%b%b count=%0d want 00 %0d", we2, we3, c3, exp_count); end
    exp_err = 1'b1;
    run_req(2'b11, 32'h0000_0003, 32'h0000_0063, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (err2 !== 1'b1 || rdy2 !== 1'b1) begin n_fail++; $display("FAIL range_b_err: got err=%b ready=%b want 1 1", err2, rdy2); end
    n_tests++; if (we2 !== 1'b0 || c3 !== exp_count) begin n_fail++; $display("FAIL range_b_nowrite: got we=%b count=%0d want 0 %0d", we2, c3, exp_count); end
`else
    run_req(2'b01, 32'h0000_0800, 32'h0000_0013, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (wd[31:20] !== 12'h800 || we2 !== 1'b1) begin n_fail++; $display("FAIL range_drop: got we=%b field=%h want 1 800", we2, wd[31:20]); end
    n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL range_noerr: got %b want 0", err2); end
    exp_count++;
`endif
  endtask

  task automatic test_random();
    logic we1, we2, we3, err2, rdy2, rdy3;
    logic [7:0] wa; logic [31:0] wd; logic [8:0] c3;
    logic [1:0] fmt; logic [31:0] imm, base;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      fmt  = 2'($urandom_range(0, 3));
      imm  = ($urandom_range(0, 3) != 0) ? legal_imm(fmt) : $urandom;
      base = $urandom;
      ok   = model_ok(fmt, imm);
      run_req(fmt, imm, base, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
      if (!ok) exp_err = 1'b1;
      n_tests++; if (we1 !== 1'b0 || we3 !== 1'b0 || we2 !== ok) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b%b%b want 0%b0", i, we1, we2, we3, ok); end
      if (ok) begin
        n_tests++; if (wd !== model_word(fmt, imm, base)) begin n_fail++; $display("FAIL rnd_wdata[%0d]: fmt=%0d imm=%h base=%h got %h want %h", i, fmt, imm, base, wd, model_word(fmt, imm, base)); end
        n_tests++; if (wa !== exp_count[7:0]) begin n_fail++; $display("FAIL rnd_waddr[%0d]: got %h want %h", i, wa, exp_count[7:0]); end
        exp_count++;
      end
      n_tests++; if (c3 !== exp_count) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, c3, exp_count); end
      n_tests++; if (err2 !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, err2, exp_err); end
    end
  endtask

  task automatic test_reset_mid();
    logic we1, we2, we3, err2, rdy2, rdy3;
    logic [7:0] wa; logic [31:0] wd; logic [8:0] c3;
    logic [31:0] base;
    int stray = 0;
    bus.valid_i = 1'b1; bus.ImmSrc_i = 2'b01; bus.imm_i = 32'h5; bus.base_i = 32'h13;
    @(negedge clk);
    rst = 1'b1; bus.valid_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.we_o !== 1'b0 || bus.count_o !== 9'd0) begin n_fail++; $display("FAIL rstmid_state: got we=%b count=%0d want 0 0", bus.we_o, bus.count_o); end
    n_tests++; if (bus.ready_o !== 1'b1 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got ready=%b err=%b want 1 0", bus.ready_o, bus.err_o); end
    rst = 1'b0;
    exp_count = '0; exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.we_o !== 1'b0) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL rstmid_nowe: got %0d writes want 0", stray); end
    base = $urandom;
    run_req(2'b00, $urandom, base, we1, we2, we3, err2, rdy2, rdy3, wa, wd, c3);
    n_tests++; if (we2 !== 1'b1 || wa !== 8'd0 || wd !== base) begin n_fail++; $display("FAIL rstmid_next: got we=%b addr=%h data=%h want 1 0 %h", we2, wa, wd, base); end
    exp_count = 9'd1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] want;
    logic [1:0] fmt;
    int last_we = -1;
    int nwr = 0;
    bit accepted = 1'b0;
    fmt = 2'($urandom_range(0, 3));
    bus.ImmSrc_i = fmt; bus.imm_i = legal_imm(fmt); bus.base_i = $urandom;
    bus.valid_i = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.we_o === 1'b1) begin
        want = (q.size() > 0) ? q.pop_front() : 32'hx;
        n_tests++; if (bus.wdata_o !== want) begin n_fail++; $display("FAIL b2b_wdata@%0d: got %h want %h", cyc, bus.wdata_o, want); end
        n_tests++; if (bus.waddr_o !== exp_count[7:0]) begin n_fail++; $display("FAIL b2b_waddr@%0d: got %h want %h", cyc, bus.waddr_o, exp_count[7:0]); end
        if (last_we >= 0) begin
          n_tests++; if (cyc - last_we != 3) begin n_fail++; $display("FAIL b2b_gap@%0d: got %0d want 3", cyc, cyc - last_we); end
        end
        exp_count++; nwr++; last_we = cyc;
      end
      if (accepted) begin
        fmt = 2'($urandom_range(0, 3));
        bus.ImmSrc_i = fmt; bus.imm_i = legal_imm(fmt); bus.base_i = $urandom;
        accepted = 1'b0;
      end
      if (cyc >= 33) bus.valid_i = 1'b0;
      if (bus.valid_i === 1'b1 && bus.ready_o === 1'b1) begin
        q.push_back(model_word(bus.ImmSrc_i, bus.imm_i, bus.base_i));
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    n_tests++; if (q.size() != 0 || nwr < 10) begin n_fail++; $display("FAIL b2b_drain: got %0d left %0d writes want 0 >=10", q.size(), nwr); end
  endtask

  task automatic test_full();
    logic [31:0] base;
    int waited, wes;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (sb.ready_o !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      base = $urandom;
      sb.valid_i = 1'b1; sb.ImmSrc_i = 2'b00; sb.imm_i = $urandom; sb.base_i = base;
      @(negedge clk);
      sb.valid_i = 1'b0;
      @(negedge clk);
      n_tests++; if (sb.we_o !== 1'b1 || sb.waddr_o !== 2'(k) || sb.wdata_o !== base) begin n_fail++; $display("FAIL full_write[%0d]: got we=%b addr=%0d data=%h want 1 %0d %h", k, sb.we_o, sb.waddr_o, sb.wdata_o, k, base); end
      @(negedge clk);
    end
    n_tests++; if (sb.full_o !== 1'b1 || sb.ready_o !== 1'b0) begin n_fail++; $display("FAIL full_flags: got full=%b ready=%b want 1 0", sb.full_o, sb.ready_o); end
    n_tests++; if (sb.count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", sb.count_o); end
    sb.valid_i = 1'b1;
    wes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sb.we_o !== 1'b0) wes++;
    end
    sb.valid_i = 1'b0;
    n_tests++; if (wes != 0 || sb.count_o !== 3'd4 || sb.full_o !== 1'b1) begin n_fail++; $display("FAIL full_hold: got writes=%0d count=%0d full=%b want 0 4 1", wes, sb.count_o, sb.full_o); end
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.ImmSrc_i = '0; bus.imm_i = '0; bus.base_i = '0;
    sb.valid_i  = 1'b0; sb.ImmSrc_i  = '0; sb.imm_i  = '0; sb.base_i  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_range();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
